tbird_input_conditioner: RTL and testbench

Front-end stage of the T-Bird tail-light sequencer. It sits directly upstream of the light-sequencing FSM and the 7-segment mode display. It takes the raw slide switches sw0/sw1 and synchronises and debounces them as a pair. It then decodes them into a committed turn-signal mode and produces the step-rate tick that advances the LED pattern. Downstream logic sees only clean, single-clock-domain mode/tick signals.

---
 rtl/tbird_pkg.sv | 22 ++
 rtl/tbird_sync2.sv | 22 ++
 rtl/tbird_input_conditioner.sv | 108 ++++++++++
 tb/tb_tbird_input_conditioner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared types and defaults for the T-Bird tail-light design.
package tbird_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 10 ms debounce window and 250 ms step period at CLK_HZ.
  localparam int unsigned DEB_CYCLES_DEF  = CLK_HZ / 100;
  localparam int unsigned TICK_CYCLES_DEF = CLK_HZ / 4;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_ERROR = 2'b11
  } mode_t;

  // The switch pair maps directly onto the mode encoding: {left, right}.
  function automatic mode_t decode_mode(input logic sw_right, input logic sw_left);
    return mode_t'({sw_left, sw_right});
  endfunction

endpackage

// File: rtl/tbird_sync2.sv
// Two-flop synchroniser for one asynchronous input bit.
module tbird_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tbird_input_conditioner.sv
// Synchronises and jointly debounces the turn switches, commits the
// turn-signal mode and generates the LED step tick.
module tbird_input_conditioner
  import tbird_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw0,
  input  logic       sw1,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic       step_tick
);

  localparam int unsigned DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic sw0_s;
  logic sw1_s;
  mode_t s;

  mode_t             cand,          cand_d;
  logic [DEB_W-1:0]  deb_cnt,       deb_cnt_d;
  mode_t             mode_q,        mode_d;
  logic              mode_change_d;
  logic [TICK_W-1:0] tick_cnt,      tick_cnt_d;
  logic              step_tick_d;

  logic commit;
  logic tick_term;

  tbird_sync2 u_sync_sw0 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw0),
    .q     (sw0_s)
  );

  tbird_sync2 u_sync_sw1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw1),
    .q     (sw1_s)
  );

  assign s    = decode_mode(sw0_s, sw1_s);
  assign mode = mode_q;

  // Next-state logic for debounce, commit and tick generation.
  always_comb begin
    cand_d        = cand;
    deb_cnt_d     = deb_cnt;
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    tick_cnt_d    = tick_cnt;
    step_tick_d   = 1'b0;

    // A commit needs the pair to have matched the candidate for the whole window.
    commit    = (s == cand) && (deb_cnt == DEB_LAST) && (cand != mode_q);
    tick_term = (tick_cnt == TICK_LAST);

    // Debounce the pair as a vector so staggered bit changes restart the window.
    if (s != cand) begin
      cand_d    = s;
      deb_cnt_d = '0;
    end else if (deb_cnt != DEB_LAST) begin
      deb_cnt_d = deb_cnt + DEB_W'(1);
    end

    // A commit wins over a coincident terminal tick count and restarts the phase.
    if (commit) begin
      mode_d        = cand;
      mode_change_d = 1'b1;
      tick_cnt_d    = '0;
    end else if (mode_q == MODE_IDLE) begin
      tick_cnt_d = '0;
    end else begin
      step_tick_d = tick_term;
      tick_cnt_d  = tick_term ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= MODE_IDLE;
      deb_cnt     <= '0;
      mode_q      <= MODE_IDLE;
      mode_change <= 1'b0;
      tick_cnt    <= '0;
      step_tick   <= 1'b0;
    end else begin
      cand        <= cand_d;
      deb_cnt     <= deb_cnt_d;
      mode_q      <= mode_d;
      mode_change <= mode_change_d;
      tick_cnt    <= tick_cnt_d;
      step_tick   <= step_tick_d;
    end
  end

endmodule

// File: tb/tb_tbird_input_conditioner.sv
// Bench for tbird_input_conditioner with DEB_CYCLES=4, TICK_CYCLES=8.
module tb_tbird_input_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw0;
  logic       sw1;
  logic [1:0] mode;
  logic       mode_change;
  logic       step_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tbird_input_conditioner #(
    .DEB_CYCLES  (DEB),
    .TICK_CYCLES (TICK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw0         (sw0),
    .sw1         (sw1),
    .mode        (mode),
    .mode_change (mode_change),
    .step_tick   (step_tick)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic       chg;
    logic       tick;
  } obs_t;

  typedef struct {
    logic [1:0] sw;
    int         cycles;
    logic [1:0] mode;
    int         pulses;
    int         ticks;
  } row_t;

  obs_t       sbq[$];
  logic [1:0] hist[$];
  int         n;
  logic [1:0] m_mode;
  int         last_commit;
  bit         have_commit;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference: history of switch samples since reset (pre-release samples read as 00).
  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 8; k++) hist.push_back(2'b00);
    n           = 0;
    m_mode      = 2'b00;
    have_commit = 1'b0;
    last_commit = 0;
  endtask

  // Expected outputs after the next edge; v is the switch value sampled at that edge.
  // Mode commits at edge e when samples e-6..e-2 (DEB+1 of them) all agree and differ from mode.
  task automatic predict(input logic [1:0] v);
    int         e;
    bit         commit;
    bit         all_eq;
    logic [1:0] w0;
    obs_t       o;
    e      = n + 1;
    w0     = hist[hist.size() - 2];
    all_eq = 1'b1;
    for (int k = 2; k <= int'(DEB) + 2; k++)
      if (hist[hist.size() - k] != w0) all_eq = 1'b0;
    commit = all_eq && (w0 != m_mode);
    o.tick = !commit && (m_mode != 2'b00) && have_commit &&
             (((e - last_commit) % int'(TICK)) == 0);
    if (commit) begin
      m_mode      = w0;
      last_commit = e;
      have_commit = 1'b1;
    end
    o.mode = m_mode;
    o.chg  = commit;
    sbq.push_back(o);
    hist.push_back(v);
    if (hist.size() > 8) void'(hist.pop_front());
    n = e;
  endtask

  // One clock: drive at negedge, predict, sample at the following negedge.
  task automatic cycle(input logic [1:0] v, output logic chg, output logic tk);
    obs_t o;
    {sw1, sw0} = v;
    predict(v);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard edge %0d: no expectation queued", n);
    end else begin
      o = sbq.pop_front();
      if ({mode, mode_change, step_tick} != o) begin
        bad++;
        $display("FAIL edge %0d: got mode=%b chg=%b tick=%b want mode=%b chg=%b tick=%b",
                 n, mode, mode_change, step_tick, o.mode, o.chg, o.tick);
      end
    end
    chg = mode_change;
    tk  = step_tick;
  endtask

  initial begin
    row_t       tbl[$];
    row_t       r;
    logic       c;
    logic       t;
    int         pulses;
    int         ticks;
    int         first;

    // Phases after reset release; edge numbers count from release.
    tbl.push_back('{2'b11, 10, 2'b11, 1, 0});   // edges 1-10: commit ERROR at 7
    tbl.push_back('{2'b00, 10, 2'b00, 1, 1});   // 11-20: tick at 15, commit IDLE at 17
    for (int i = 0; i < 10; i++) begin          // 21-40: bounce sw0 every 2 cycles
      r.sw     = (i % 2 == 0) ? 2'b01 : 2'b00;
      r.cycles = 2;
      r.mode   = 2'b00;
      r.pulses = 0;
      r.ticks  = 0;
      tbl.push_back(r);
    end
    tbl.push_back('{2'b01, 35, 2'b01, 1, 3});   // 41-75: commit RIGHT at 47, ticks 55/63/71
    tbl.push_back('{2'b11,  1, 2'b01, 0, 0});   // 76: one-cycle 11 transient
    tbl.push_back('{2'b10, 19, 2'b10, 1, 2});   // 77-95: tick 79, commit LEFT 83, tick 91
    tbl.push_back('{2'b00, 60, 2'b00, 1, 1});   // 96-155: tick 99, commit IDLE 102, silent
    tbl.push_back('{2'b10, 15, 2'b10, 1, 1});   // 156-170: commit LEFT 162, tick 170

    // Reset held with both switches on.
    rst_n = 1'b0;
    {sw1, sw0} = 2'b11;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_mode", int'(mode), 0);
    check("reset_tick", int'(step_tick), 0);
    check("reset_chg", int'(mode_change), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      pulses = 0;
      ticks  = 0;
      for (int k = 0; k < tbl[i].cycles; k++) begin
        cycle(tbl[i].sw, c, t);
        pulses += int'(c);
        ticks  += int'(t);
      end
      check($sformatf("row%0d_mode", i), int'(mode), int'(tbl[i].mode));
      check($sformatf("row%0d_pulses", i), pulses, tbl[i].pulses);
      check($sformatf("row%0d_ticks", i), ticks, tbl[i].ticks);
    end

    // Async reset while step_tick is high in LEFT: outputs clear before the next edge.
    check("pre_reset_tick", int'(step_tick), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_mode", int'(mode), 0);
    check("async_tick", int'(step_tick), 0);
    check("async_chg", int'(mode_change), 0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // With switches already at 10, a full window is still needed after release.
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(2'b10, c, t);
      if (c) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("rerelease_commit_edge", first, 7);
    check("rerelease_pulses", pulses, 1);
    check("rerelease_mode", int'(mode), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
